cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 3, giving the number of completion requesters (index 0 = ALU RS, 1 = LSB, 2 = spare unit).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 2, giving the buffer entries held per requester.
REQ-003 The block SHALL have port clk_in, input, 1, the system clock; the block uses one clock.
REQ-004 The block SHALL have port rst_in, input, 1, a synchronous, active-low reset.
REQ-005 The block SHALL have port rdy_in, input, 1; when low, the CPU is paused.
REQ-006 The block SHALL have port flush_in, input, 1, driven by rob_clear; it discards all in-flight results.
REQ-007 The block SHALL have port req_valid, input, NUM_REQ, the per-requester result-valid signals.
REQ-008 The block SHALL have port req_value, input, NUM_REQ*32, with requester i's result in bits [32i+31:32i].
REQ-009 The block SHALL have port req_rob_id, input, NUM_REQ*ROB_SIZE_BIT, with requester i's ROB id in its slice.
REQ-010 The block SHALL have port req_ready, output, NUM_REQ, meaning requester i may hand over a result this cycle.
REQ-011 The block SHALL have port cdb_valid, output, 1, the registered broadcast strobe to the ROB, RS and LSB.
REQ-012 The block SHALL have port cdb_value, output, 32, the registered broadcast result.
REQ-013 The block SHALL have port cdb_rob_id, output, ROB_SIZE_BIT, the registered broadcast ROB id.

Function
REQ-014 Each requester SHALL own a FIFO_DEPTH-entry FIFO of {value, rob_id} with a registered count 0..FIFO_DEPTH.
REQ-015 req_ready[i] SHALL be exactly rdy_in && !flush_in && count[i] < FIFO_DEPTH, derived from registered state and not from a same-cycle pop.
REQ-016 A push SHALL occur at a rising edge where req_valid[i] && req_ready[i]; a valid input without ready SHALL be ignored, and the requester SHALL hold it.
REQ-017 Each cycle with rdy_in high and flush_in low, the arbiter SHALL grant the first non-empty FIFO found scanning from rr_ptr upward, modulo NUM_REQ.
REQ-018 On a grant, the head entry SHALL pop, cdb_valid/cdb_value/cdb_rob_id SHALL load it at that edge, and rr_ptr SHALL become (winner+1) mod NUM_REQ.
REQ-019 With no FIFO non-empty, cdb_valid SHALL be 0 next cycle, and rr_ptr and cdb_value/cdb_rob_id SHALL hold.
REQ-020 Latency: a result pushed at edge T into an empty, uncontended system SHALL appear with cdb_valid=1 in the cycle after edge T+1.
REQ-021 A push and a pop on the same FIFO at one edge SHALL leave count unchanged and preserve FIFO order.
REQ-022 Read and write pointers SHALL wrap modulo FIFO_DEPTH; per-requester order SHALL be strictly preserved.
REQ-023 At most one broadcast SHALL occur per cycle; cdb_valid SHALL never be high for two ids in one cycle.
REQ-024 Flush: at an edge with rdy_in=1 and flush_in=1, all counts and pointers SHALL clear, cdb_valid SHALL become 0, rr_ptr SHALL become 0, and same-cycle inputs SHALL be dropped.
REQ-025 Flush SHALL take priority over push and grant in the same cycle.
REQ-026 When rdy_in=0, no state SHALL change, the cdb outputs SHALL hold their values, and req_ready SHALL be 0.

Reset
REQ-027 At an edge with rst_in=0, all counts, pointers and rr_ptr SHALL reset to 0, cdb_valid SHALL be 0, and cdb_value and cdb_rob_id SHALL be 0, regardless of rdy_in.
REQ-028 Reset asserted mid-operation SHALL discard buffered results, and the first broadcast after release SHALL be no earlier than the cycle after edge T+1 of a new push at T.

Structure
REQ-029 ROB_SIZE_BIT, CDB_NUM_REQ and CDB_FIFO_DEPTH SHALL live in the shared Config.v constants file.
REQ-030 The per-requester buffer SHALL be one sub-module, cdb_fifo, instantiated NUM_REQ times, exposing push, pop, flush, count, head data and head id.

Verification
REQ-031 Single push: req_valid=001, value 0x0000_00AA, id 5 -> cdb_valid=1, value 0xAA, id 5 exactly two edges later; then cdb_valid=0.
REQ-032 Three-way contention with all FIFOs holding one entry and rr_ptr=0 -> broadcasts ids from requester 0, then 1, then 2 on consecutive cycles, and rr_ptr ends at 0.
REQ-033 Backpressure: hold req_valid[1]=1 with 4 distinct ids while requester 0 is always granted first -> req_ready[1] drops at count 2, and all 4 ids are broadcast in order, none lost.
REQ-034 Flush: with 2 entries in each FIFO, pulse flush_in for one cycle -> the next cycle has cdb_valid=0, all req_ready=1, and no pre-flush id is ever broadcast.
REQ-035 Pause: set rdy_in=0 for 3 cycles with entries buffered -> cdb outputs are frozen and req_ready=0, and after release the broadcast order is identical to the unpaused run.
REQ-036 Reset mid-stream: drive rst_in=0 for one edge with FIFOs partly full -> all outputs are 0 next cycle, and a new push of id 3 broadcasts after two edges.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and the buffered completion-entry type for the CDB arbiter.
package cdb_arbiter_pkg;

    localparam int ROB_SIZE_BIT   = 4;
    localparam int CDB_NUM_REQ    = 3;
    localparam int CDB_FIFO_DEPTH = 2;
    localparam int CDB_DATA_W     = 32;

    typedef struct packed {
        logic [CDB_DATA_W-1:0]   value;
        logic [ROB_SIZE_BIT-1:0] rob_id;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_fifo.sv
// Per-requester completion buffer: small circular FIFO of {value, rob_id}.
module cdb_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter  int DEPTH = CDB_FIFO_DEPTH,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    en,
    input  logic                    flush,
    input  logic                    push,
    input  logic                    pop,
    input  logic [CDB_DATA_W-1:0]   push_value,
    input  logic [ROB_SIZE_BIT-1:0] push_id,
    output logic [CNT_W-1:0]        count,
    output logic [CDB_DATA_W-1:0]   head_value,
    output logic [ROB_SIZE_BIT-1:0] head_id
);

    cdb_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (en) begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= next_ptr(wr_ptr);
                if (pop)  rd_ptr <= next_ptr(rd_ptr);
                if (push && !pop)      count <= count + CNT_W'(1);
                else if (pop && !push) count <= count - CNT_W'(1);
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; its contents are
    // only observed while count is non-zero, which reset already guarantees.
    always_ff @(posedge clk_in) begin
        if (en && !flush && push) mem[wr_ptr] <= '{value: push_value, rob_id: push_id};
    end

    assign head_value = mem[rd_ptr].value;
    assign head_id    = mem[rd_ptr].rob_id;

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers completions per unit and broadcasts one
// result per cycle, round-robin across requesters.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = CDB_NUM_REQ,
    parameter int FIFO_DEPTH = CDB_FIFO_DEPTH
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            rdy_in,
    input  logic                            flush_in,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*CDB_DATA_W-1:0]   req_value,
    input  logic [NUM_REQ*ROB_SIZE_BIT-1:0] req_rob_id,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            cdb_valid,
    output logic [CDB_DATA_W-1:0]           cdb_value,
    output logic [ROB_SIZE_BIT-1:0]         cdb_rob_id
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [CNT_W-1:0]        count      [NUM_REQ];
    logic [CDB_DATA_W-1:0]   head_value [NUM_REQ];
    logic [ROB_SIZE_BIT-1:0] head_id    [NUM_REQ];
    logic [NUM_REQ-1:0]      push;
    logic [NUM_REQ-1:0]      pop;
    logic [NUM_REQ-1:0]      nonempty;
    logic [IDX_W-1:0]        rr_ptr;
    logic [IDX_W-1:0]        win_idx;
    logic [IDX_W-1:0]        cand;
    logic [IDX_W:0]          cand_sum;
    logic                    win_found;
    logic                    active;

    assign active = rdy_in && !flush_in;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign nonempty[i]  = (count[i] != '0);
        assign req_ready[i] = active && (count[i] < CNT_W'(FIFO_DEPTH));
        assign push[i]      = req_valid[i] && req_ready[i];
        assign pop[i]       = active && win_found && (win_idx == IDX_W'(i));

        cdb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk_in     (clk_in),
            .rst_in     (rst_in),
            .en         (rdy_in),
            .flush      (flush_in),
            .push       (push[i]),
            .pop        (pop[i]),
            .push_value (req_value[CDB_DATA_W*i +: CDB_DATA_W]),
            .push_id    (req_rob_id[ROB_SIZE_BIT*i +: ROB_SIZE_BIT]),
            .count      (count[i]),
            .head_value (head_value[i]),
            .head_id    (head_id[i])
        );
    end

    // NOTE: every variable assigned here gets a default first, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
            if (cand_sum >= (IDX_W + 1)'(NUM_REQ)) cand_sum = cand_sum - (IDX_W + 1)'(NUM_REQ);
            cand = cand_sum[IDX_W-1:0];
            if (!win_found && nonempty[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Broadcast registers hold their last payload when idle; only the strobe drops.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            cdb_valid  <= 1'b0;
            cdb_value  <= '0;
            cdb_rob_id <= '0;
            rr_ptr     <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                cdb_valid <= 1'b0;
                rr_ptr    <= '0;
            end else if (win_found) begin
                cdb_valid  <= 1'b1;
                cdb_value  <= head_value[win_idx];
                cdb_rob_id <= head_id[win_idx];
                rr_ptr     <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NR = 3;
    localparam int D  = 2;
    localparam int IW = ROB_SIZE_BIT;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b0;
    logic              rdy_in = 1'b1;
    logic              flush_in = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*32-1:0]  req_value = '0;
    logic [NR*IW-1:0]  req_rob_id = '0;
    logic [NR-1:0]     req_ready;
    logic              cdb_valid;
    logic [31:0]       cdb_value;
    logic [IW-1:0]     cdb_rob_id;

    cdb_arbiter #(.NUM_REQ(NR), .FIFO_DEPTH(D)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .flush_in   (flush_in),
        .req_valid  (req_valid),
        .req_value  (req_value),
        .req_rob_id (req_rob_id),
        .req_ready  (req_ready),
        .cdb_valid  (cdb_valid),
        .cdb_value  (cdb_value),
        .cdb_rob_id (cdb_rob_id)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one queue per requester plus the broadcast registers.
    logic [32+IW-1:0] mq [NR][$];
    int               m_rr    = 0;
    logic             m_valid = 1'b0;
    logic [31:0]      m_value = '0;
    logic [IW-1:0]    m_id    = '0;

    // Values observed on the last step.
    logic [NR-1:0] s_ready;
    logic          s_valid;
    logic [31:0]   s_value;
    logic [IW-1:0] s_id;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [NR*32-1:0] pv(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return {c, b, a};
    endfunction

    function automatic logic [NR*IW-1:0] pi(input logic [IW-1:0] a, input logic [IW-1:0] b, input logic [IW-1:0] c);
        return {c, b, a};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mq[i].delete();
        m_rr = 0; m_valid = 1'b0; m_value = '0; m_id = '0;
    endtask

    // One clock cycle: drive inputs, check ready before the edge and the
    // broadcast registers after it, both against the model.
    task automatic drive(input logic rst, input logic rdy, input logic flush, input logic [NR-1:0] v,
                         input logic [NR*32-1:0] val, input logic [NR*IW-1:0] ids);
        logic [NR-1:0]    er;
        logic [32+IW-1:0] e;
        int               w;
        @(negedge clk_in);
        rst_in = rst; rdy_in = rdy; flush_in = flush;
        req_valid = v; req_value = val; req_rob_id = ids;
        #1;
        for (int i = 0; i < NR; i++) er[i] = rdy && !flush && (mq[i].size() < D);
        s_ready = req_ready;
        check("req_ready", 64'(s_ready), 64'(er));
        if (!rst) begin
            model_reset();
        end else if (rdy) begin
            if (flush) begin
                for (int i = 0; i < NR; i++) mq[i].delete();
                m_valid = 1'b0; m_rr = 0;
            end else begin
                w = -1;
                for (int k = 0; k < NR; k++)
                    if (w < 0 && mq[(m_rr + k) % NR].size() > 0) w = (m_rr + k) % NR;
                if (w >= 0) begin
                    e = mq[w].pop_front();
                    m_valid = 1'b1; m_value = e[32+IW-1:IW]; m_id = e[IW-1:0];
                    m_rr = (w + 1) % NR;
                end else begin
                    m_valid = 1'b0;
                end
                for (int i = 0; i < NR; i++)
                    if (v[i] && er[i]) mq[i].push_back({val[32*i +: 32], ids[IW*i +: IW]});
            end
        end
        @(posedge clk_in);
        #1;
        s_valid = cdb_valid; s_value = cdb_value; s_id = cdb_rob_id;
        check("cdb_valid", 64'(s_valid), 64'(m_valid));
        check("cdb_value", 64'(s_value), 64'(m_value));
        check("cdb_rob_id", 64'(s_id), 64'(m_id));
    endtask

    typedef struct {
        logic             rst, rdy, flush;
        logic [NR-1:0]    v;
        logic [NR*32-1:0] val;
        logic [NR*IW-1:0] ids;
        logic [NR-1:0]    e_ready;
        logic             e_valid;
        logic [31:0]      e_value;
        logic [IW-1:0]    e_id;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic rdy, input logic flush, input logic [NR-1:0] v,
                                input logic [NR*32-1:0] val, input logic [NR*IW-1:0] ids,
                                input logic [NR-1:0] er, input logic ev, input logic [31:0] eval,
                                input logic [IW-1:0] eid);
        vec_t t;
        t.rst = rst; t.rdy = rdy; t.flush = flush; t.v = v; t.val = val; t.ids = ids;
        t.e_ready = er; t.e_valid = ev; t.e_value = eval; t.e_id = eid;
        return t;
    endfunction

    initial begin
        int            k;
        bit            saw_block;
        logic [IW-1:0] got_ids[$];
        logic [IW-1:0] id1;

        for (int i = 0; i < NR; i++) mq[i].delete();
        repeat (2) @(posedge clk_in);

        // Reset state, single push latency, three-way round robin, rr_ptr wrap.
        tbl.push_back(mk(0, 1, 0, 3'b000, '0, '0, 3'b111, 0, 32'h0, 4'd0));
        tbl.push_back(mk(1, 1, 0, 3'b001, pv(32'hAA, 0, 0), pi(4'd5, 0, 0), 3'b111, 0, 32'h0, 4'd0));
        tbl.push_back(mk(1, 1, 0, 3'b000, '0, '0, 3'b111, 1, 32'hAA, 4'd5));
        tbl.push_back(mk(1, 1, 0, 3'b000, '0, '0, 3'b111, 0, 32'hAA, 4'd5));
        tbl.push_back(mk(1, 1, 1, 3'b000, '0, '0, 3'b000, 0, 32'hAA, 4'd5));
        tbl.push_back(mk(1, 1, 0, 3'b111, pv(32'h100, 32'h101, 32'h102), pi(4'd1, 4'd2, 4'd3), 3'b111, 0, 32'hAA, 4'd5));
        tbl.push_back(mk(1, 1, 0, 3'b000, '0, '0, 3'b111, 1, 32'h100, 4'd1));
        tbl.push_back(mk(1, 1, 0, 3'b000, '0, '0, 3'b111, 1, 32'h101, 4'd2));
        tbl.push_back(mk(1, 1, 0, 3'b000, '0, '0, 3'b111, 1, 32'h102, 4'd3));
        tbl.push_back(mk(1, 1, 0, 3'b000, '0, '0, 3'b111, 0, 32'h102, 4'd3));
        tbl.push_back(mk(1, 1, 0, 3'b101, pv(32'h200, 0, 32'h202), pi(4'd9, 0, 4'd10), 3'b111, 0, 32'h102, 4'd3));
        tbl.push_back(mk(1, 1, 0, 3'b000, '0, '0, 3'b111, 1, 32'h200, 4'd9));
        tbl.push_back(mk(1, 1, 0, 3'b000, '0, '0, 3'b111, 1, 32'h202, 4'd10));
        tbl.push_back(mk(1, 1, 0, 3'b000, '0, '0, 3'b111, 0, 32'h202, 4'd10));

        foreach (tbl[n]) begin
            drive(tbl[n].rst, tbl[n].rdy, tbl[n].flush, tbl[n].v, tbl[n].val, tbl[n].ids);
            check("tbl_ready", 64'(s_ready), 64'(tbl[n].e_ready));
            check("tbl_valid", 64'(s_valid), 64'(tbl[n].e_valid));
            check("tbl_value", 64'(s_value), 64'(tbl[n].e_value));
            check("tbl_id", 64'(s_id), 64'(tbl[n].e_id));
        end

        // Backpressure: requester 1 holds each result until accepted.
        drive(1, 1, 1, '0, '0, '0);
        k = 0; saw_block = 0; got_ids.delete();
        for (int c = 0; c < 60 && got_ids.size() < 4; c++) begin
            id1 = IW'(k + 1);
            drive(1, 1, 0, {1'b0, k < 4, 1'b1}, pv(32'h0, 32'(32'h1000 + k), 32'h0), pi(4'd0, id1, 4'd0));
            if (k < 4 && !s_ready[1]) saw_block = 1;
            if (k < 4 && s_ready[1]) k++;
            if (s_valid && s_value[12]) got_ids.push_back(s_id);
        end
        check("bp_ready_dropped", 64'(saw_block), 64'd1);
        check("bp_count", 64'(got_ids.size()), 64'd4);
        foreach (got_ids[n]) check("bp_order", 64'(got_ids[n]), 64'(n + 1));

        // Flush with buffered entries: pre-flush ids (>= 8) must never appear.
        for (int c = 0; c < 3; c++)
            drive(1, 1, 0, 3'b111, pv(32'h500, 32'h501, 32'h502), pi(IW'(8 + c), 4'd12, 4'd13));
        drive(1, 1, 1, 3'b111, pv(32'h5, 32'h5, 32'h5), pi(4'd14, 4'd14, 4'd14));
        check("flush_valid", 64'(s_valid), 64'd0);
        drive(1, 1, 0, 3'b000, '0, '0);
        check("flush_ready", 64'(s_ready), 64'b111);
        check("flush_valid_next", 64'(s_valid), 64'd0);
        drive(1, 1, 0, 3'b111, pv(32'h1, 32'h2, 32'h3), pi(4'd1, 4'd2, 4'd3));
        for (int c = 0; c < 5; c++) begin
            drive(1, 1, 0, 3'b000, '0, '0);
            check("flush_leak", 64'(s_valid && s_id[3]), 64'd0);
        end

        // Pause: outputs frozen, ready low, order unchanged after release.
        drive(1, 1, 1, '0, '0, '0);
        drive(1, 1, 0, 3'b111, pv(32'h300, 32'h301, 32'h302), pi(4'd11, 4'd12, 4'd13));
        got_ids.delete();
        drive(1, 1, 0, 3'b000, '0, '0);
        if (s_valid) got_ids.push_back(s_id);
        for (int c = 0; c < 3; c++) begin
            drive(1, 0, 0, 3'b111, pv(32'h7, 32'h7, 32'h7), pi(4'd7, 4'd7, 4'd7));
            check("pause_ready", 64'(s_ready), 64'd0);
            check("pause_valid", 64'(s_valid), 64'd1);
            check("pause_value", 64'(s_value), 64'h300);
            check("pause_id", 64'(s_id), 64'd11);
        end
        for (int c = 0; c < 3; c++) begin
            drive(1, 1, 0, 3'b000, '0, '0);
            if (s_valid) got_ids.push_back(s_id);
        end
        check("pause_count", 64'(got_ids.size()), 64'd3);
        foreach (got_ids[n]) check("pause_order", 64'(got_ids[n]), 64'(11 + n));

        // Reset mid-stream (with rdy low), then a fresh push of id 3.
        drive(1, 1, 0, 3'b111, pv(32'h41, 32'h42, 32'h43), pi(4'd4, 4'd5, 4'd6));
        drive(1, 1, 0, 3'b111, pv(32'h44, 32'h45, 32'h46), pi(4'd7, 4'd8, 4'd9));
        drive(0, 0, 0, 3'b000, '0, '0);
        check("rst_valid", 64'(s_valid), 64'd0);
        check("rst_value", 64'(s_value), 64'd0);
        check("rst_id", 64'(s_id), 64'd0);
        drive(1, 1, 0, 3'b001, pv(32'h33, 0, 0), pi(4'd3, 0, 0));
        check("rst_push_t", 64'(s_valid), 64'd0);
        drive(1, 1, 0, 3'b000, '0, '0);
        check("rst_push_valid", 64'(s_valid), 64'd1);
        check("rst_push_id", 64'(s_id), 64'd3);
        drive(1, 1, 0, 3'b000, '0, '0);
        check("rst_drain", 64'(s_valid), 64'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 500; c++) begin
            drive($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
                  NR'($urandom()), {$urandom(), $urandom(), $urandom()}, (NR*IW)'($urandom()));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
